bcd_down_counter: RTL and testbench
===================================

// Module: bcd_down_counter
// PURPOSE
//   Synchronous multi-digit BCD down counter; counterpart to the team's
//   mod-10 BCD up counter (terminal count at 9).
//   Counts down one per enabled clock from a loaded value, with
//   per-digit borrow ripple, zero detect and borrow-out.
//   Used for countdown timers and for cascading with further counter stages.
// PARAMETERS
//   DIGITS  2  number of BCD digits (1..8); count width = 4*DIGITS
//   WRAP    1  1: 0 wraps to all-9s on enabled tick; 0: saturate/hold at 0
// PORTS
//   clk   in   1         rising-edge clock (single clock domain)
//   rst   in   1         synchronous reset, active-high
//   load  in   1         load din into count this edge
//   din   in   4*DIGITS  BCD load value, digit 0 = din[3:0] (least significant)
//   e     in   1         count enable (decrement by 1 this edge)
//   q     out  4*DIGITS  current BCD count, registered
//   zero  out  1         registered; 1 when q == 0
//   bo    out  1         combinational borrow-out = e & ~load & (q == 0)
//   err   out  1         registered, sticky: last load contained a nibble > 9
// BEHAVIOUR
//   Reset (rst=1 at posedge): q=0, zero=1, err=0. Overrides load and e.
//   Priority per edge: rst > load > e > hold.
//   Load: q <= din, 1-cycle latency (new value visible after edge).
//     Each nibble > 9 is loaded as 9. err <= 1 if any nibble > 9, else 0.
//     A load with e=1 ignores e; no decrement that cycle, bo=0.
//   Decrement (e=1, load=0), per digit i, LSD first:
//     borrow_in(0)=1; borrow_in(i+1) = borrow_in(i) & (q_i == 0)
//     if borrow_in(i): q_i <= (q_i == 0) ? 9 : q_i - 1; else hold
//     Borrow ripple is combinational within one cycle; full ripple
//     (e.g. 100 -> 099) completes in one edge.
//   At q == 0 with e=1, load=0:
//     WRAP=1: q <= all 9s (e.g. 99 for DIGITS=2); bo=1 that cycle.
//     WRAP=0: q holds 0; bo=1 that cycle.
//   zero tracks the registered q (updated on the same edge as q).
//   err only changes on load or rst; it is unaffected by counting.
//   e=0 and load=0: all registers hold.
//   Non-BCD nibbles never appear on q (the load path clamps them).
//   bo is meant to drive e of the next, more significant cascaded stage.
// TESTING
//   1. rst=1 for 1 cycle, then e=0 -> q=00, zero=1, err=0, bo=0;
//      rst=1 with load=1, din=0x55 -> q stays 00.
//   2. load din=0x12, then e=1 for 12 cycles -> q = 11,10,09..01,00;
//      zero=1 only after the 12th edge; 10 -> 09 is a single edge.
//   3. WRAP=1, q=00, e=1 -> bo=1 during that cycle, next q=99, zero=0;
//      WRAP=0, same stimulus -> q stays 00, bo=1.
//   4. load din=0x3C -> q=0x39, err=1; 5 enabled ticks leave err=1;
//      load 0x20 -> err=0.
//   5. load=1 and e=1 together with din=0x50 -> q=50, bo=0;
//      rst asserted mid-count at q=37 -> next q=00.
//   6. DIGITS=3: load 0x100, e=1 -> 099; random load/e/rst sequence
//      checked against a reference model ((value - 1) mod 10^DIGITS).

Source files
------------

// File: rtl/bcd_down_counter.sv
// ---------------------------------------------------------------------------
// bcd_down_counter
//   Synchronous multi-digit BCD down counter with loadable start value,
//   single-edge borrow ripple across all digits, zero detect, sticky
//   load-error flag and a combinational borrow-out for cascading.
//
// Parameters
//   DIGITS : number of BCD digits (1..8); count width is 4*DIGITS
//   WRAP   : 1 = 0 wraps to all 9s on an enabled tick, 0 = hold at 0
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high (q=0, zero=1, err=0)
//   load : load din into the count on this edge (has priority over e)
//   din  : BCD load value, digit 0 in din[3:0]; nibbles > 9 load as 9
//   e    : count enable, decrement by one on this edge
//   q    : registered BCD count
//   zero : registered, high when q == 0
//   bo   : combinational borrow-out, e & ~load & (q == 0)
//   err  : registered, sticky until the next load/reset; set when the
//          most recent load contained a nibble > 9
// ---------------------------------------------------------------------------
module bcd_down_counter #(
    parameter int unsigned DIGITS = 2,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  e,
    output logic [4*DIGITS-1:0]   q,
    output logic                  zero,
    output logic                  bo,
    output logic                  err
);

    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic                zero_q, zero_d;
    logic                err_q, err_d;

    logic [4*DIGITS-1:0] dec_val;
    logic [4*DIGITS-1:0] load_val;
    logic                load_bad;
    logic                borrow;
    logic [3:0]          dig;

    // Decrement path: the borrow walks up from the LSD and stops at the
    // first non-zero digit. If it survives past the MSD the count was 0.
    always_comb begin
        dec_val = cnt_q;
        borrow  = 1'b1;
        dig     = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = cnt_q[4*i +: 4];
            if (borrow) begin
                dec_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
            borrow = borrow & (dig == 4'd0);
        end
        // Saturating variant: at 0 the "all 9s" result is discarded.
        if (!WRAP && borrow) begin
            dec_val = cnt_q;
        end
    end

    // Load path: clamp every non-BCD nibble to 9 and flag it.
    always_comb begin
        load_val = din;
        load_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (din[4*i +: 4] > 4'd9) begin
                load_val[4*i +: 4] = 4'd9;
                load_bad           = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (load) begin
            cnt_d = load_val;
            err_d = load_bad;
        end else if (e) begin
            cnt_d = dec_val;
        end
        zero_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
            err_q  <= err_d;
        end
    end

    assign q    = cnt_q;
    assign zero = zero_q;
    assign err  = err_q;
    // zero_q always mirrors (cnt_q == 0), so it serves as the zero term here.
    assign bo   = e & ~load & zero_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_down_counter
//   Drives three counter instances from one stimulus stream:
//     u_w2 : DIGITS=2, WRAP=1
//     u_s2 : DIGITS=2, WRAP=0
//     u_w3 : DIGITS=3, WRAP=1
//   A decimal reference model per instance is checked every cycle, and
//   directed sequences carry hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_bcd_down_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        e = 1'b0;
    logic [11:0] din = '0;

    logic [7:0]  q_w2, q_s2;
    logic [11:0] q_w3;
    logic        zero_w2, zero_s2, zero_w3;
    logic        bo_w2, bo_s2, bo_w3;
    logic        err_w2, err_s2, err_w3;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) u_w2 (
        .clk(clk), .rst(rst), .load(load), .din(din[7:0]), .e(e),
        .q(q_w2), .zero(zero_w2), .bo(bo_w2), .err(err_w2)
    );
    bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) u_s2 (
        .clk(clk), .rst(rst), .load(load), .din(din[7:0]), .e(e),
        .q(q_s2), .zero(zero_s2), .bo(bo_s2), .err(err_s2)
    );
    bcd_down_counter #(.DIGITS(3), .WRAP(1'b1)) u_w3 (
        .clk(clk), .rst(rst), .load(load), .din(din), .e(e),
        .q(q_w3), .zero(zero_w3), .bo(bo_w3), .err(err_w3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (decimal arithmetic) ----------------
    int nd[3] = '{2, 2, 3};
    bit wr[3] = '{1'b1, 1'b0, 1'b1};
    int mv[3];
    bit merr[3];
    bit mvalid = 1'b0;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int clamp_value(input logic [11:0] d, input int n);
        int v = 0;
        int nib;
        for (int i = 0; i < n; i++) begin
            nib = int'((d >> (4 * i)) & 12'hF);
            if (nib > 9) nib = 9;
            v = v + nib * pow10(i);
        end
        return v;
    endfunction

    function automatic bit clamp_err(input logic [11:0] d, input int n);
        bit b = 1'b0;
        for (int i = 0; i < n; i++)
            if (((d >> (4 * i)) & 12'hF) > 12'd9) b = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < 8; i++) begin
            r = r | (32'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mv[k]   = 0;
                merr[k] = 1'b0;
            end else if (load) begin
                mv[k]   = clamp_value(din, nd[k]);
                merr[k] = clamp_err(din, nd[k]);
            end else if (e) begin
                if (mv[k] == 0) mv[k] = wr[k] ? pow10(nd[k]) - 1 : 0;
                else            mv[k] = mv[k] - 1;
            end
        end
        if (rst) mvalid = 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mvalid) begin
            check("w2.q",    32'(q_w2),    to_bcd(mv[0]));
            check("w2.zero", 32'(zero_w2), 32'(mv[0] == 0));
            check("w2.err",  32'(err_w2),  32'(merr[0]));
            check("w2.bo",   32'(bo_w2),   32'(e & ~load & (mv[0] == 0)));
            check("s2.q",    32'(q_s2),    to_bcd(mv[1]));
            check("s2.zero", 32'(zero_s2), 32'(mv[1] == 0));
            check("s2.err",  32'(err_s2),  32'(merr[1]));
            check("s2.bo",   32'(bo_s2),   32'(e & ~load & (mv[1] == 0)));
            check("w3.q",    32'(q_w3),    to_bcd(mv[2]));
            check("w3.zero", 32'(zero_w3), 32'(mv[2] == 0));
            check("w3.err",  32'(err_w3),  32'(merr[2]));
            check("w3.bo",   32'(bo_w3),   32'(e & ~load & (mv[2] == 0)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic l, input logic en, input logic [11:0] d);
        rst = r; load = l; e = en; din = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic l, input logic en, input logic [11:0] d);
        drive(r, l, en, d);
        tick();
    endtask

    initial begin
        #1;
        // 1. reset, then reset overriding a load
        step(1'b1, 1'b0, 1'b0, 12'h000);
        drive(1'b0, 1'b0, 1'b0, 12'h000);
        #1;
        check("t1.q",    32'(q_w2),    32'h00);
        check("t1.zero", 32'(zero_w2), 32'h1);
        check("t1.err",  32'(err_w2),  32'h0);
        check("t1.bo",   32'(bo_w2),   32'h0);
        tick();
        step(1'b1, 1'b1, 1'b0, 12'h055);
        check("t1.rst_over_load", 32'(q_w2), 32'h00);

        // 2. load 12, count down through 10 -> 09 to 00
        step(1'b0, 1'b1, 1'b0, 12'h012);
        check("t2.load", 32'(q_w2), 32'h12);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b0, 1'b1, 12'h000);
            if (k == 2)  check("t2.q10", 32'(q_w2), 32'h10);
            if (k == 3)  check("t2.q09", 32'(q_w2), 32'h09);
            if (k < 12)  check("t2.zero_lo", 32'(zero_w2), 32'h0);
            if (k == 12) begin
                check("t2.q00",    32'(q_w2),    32'h00);
                check("t2.zero_hi", 32'(zero_w2), 32'h1);
            end
        end

        // 3. enabled tick at 00: wrap vs saturate
        drive(1'b0, 1'b0, 1'b1, 12'h000);
        #1;
        check("t3.bo_wrap", 32'(bo_w2), 32'h1);
        check("t3.bo_sat",  32'(bo_s2), 32'h1);
        tick();
        check("t3.q_wrap",    32'(q_w2),    32'h99);
        check("t3.zero_wrap", 32'(zero_w2), 32'h0);
        check("t3.q_sat",     32'(q_s2),    32'h00);
        check("t3.q3_wrap",   32'(q_w3),    32'h999);
        check("t3.bo_sat2",   32'(bo_s2),   32'h1);
        tick();

        // 4. clamped load sets err; counting leaves it; clean load clears it
        step(1'b0, 1'b1, 1'b0, 12'h03C);
        check("t4.clamp", 32'(q_w2),   32'h39);
        check("t4.err",   32'(err_w2), 32'h1);
        repeat (5) step(1'b0, 1'b0, 1'b1, 12'h000);
        check("t4.q34",      32'(q_w2),   32'h34);
        check("t4.err_hold", 32'(err_w2), 32'h1);
        step(1'b0, 1'b1, 1'b0, 12'h020);
        check("t4.err_clr", 32'(err_w2), 32'h0);
        check("t4.q20",     32'(q_w2),   32'h20);

        // 5. load beats enable; reset mid-count
        drive(1'b0, 1'b1, 1'b1, 12'h050);
        #1;
        check("t5.bo_load", 32'(bo_w2), 32'h0);
        tick();
        check("t5.q50", 32'(q_w2), 32'h50);
        repeat (13) step(1'b0, 1'b0, 1'b1, 12'h000);
        check("t5.q37", 32'(q_w2), 32'h37);
        step(1'b1, 1'b0, 1'b1, 12'h000);
        check("t5.rst_q",    32'(q_w2),    32'h00);
        check("t5.rst_zero", 32'(zero_w2), 32'h1);

        // 6. three-digit full ripple, then random traffic
        step(1'b0, 1'b1, 1'b0, 12'h100);
        check("t6.load100", 32'(q_w3), 32'h100);
        step(1'b0, 1'b0, 1'b1, 12'h000);
        check("t6.q099",   32'(q_w3), 32'h099);
        check("t6.w2_99",  32'(q_w2), 32'h99);
        check("t6.s2_00",  32'(q_s2), 32'h00);
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(19) == 0), ($urandom_range(7) == 0),
                 1'($urandom_range(1)), 12'($urandom));
        end

        step(1'b0, 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
